// File: rtl/fmap_writer_pkg.sv
// Shared types and sizing helpers for the YOLOv3Tiny detection-head feature-map writer.
// Defaults describe the 13x13x255x32 head.
package fmap_writer_pkg;

   localparam int unsigned DefCh          = 255;
   localparam int unsigned DefDw          = 32;
   localparam int unsigned DefOutW        = 32;
   localparam int unsigned DefFramePixels = 169;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StSend = 2'd1,
      StDone = 2'd2,
      StTag  = 2'd3
   } state_e;

   // Counter width that stays at least one bit when the count range collapses to 1.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fmap_stream_writer_if.sv
// Upstream FIFO pop port plus downstream valid/ready word stream of the feature-map writer.
import fmap_writer_pkg::*;

interface fmap_stream_writer_if #(
   parameter int unsigned CH           = DefCh,
   parameter int unsigned DW           = DefDw,
   parameter int unsigned OUT_W        = DefOutW,
   parameter int unsigned FRAME_PIXELS = DefFramePixels
) ();
   localparam int unsigned PW = cnt_w(FRAME_PIXELS);

   logic [CH*DW-1:0] data_in;
   logic             valid_in;
   logic             empty;
   logic             rd_en;
   logic [OUT_W-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;
   logic [PW-1:0]    pixel_idx;
   logic             frame_done;

   modport master (
      input  data_in, valid_in, empty, out_ready,
      output rd_en, out_data, out_valid, out_last, pixel_idx, frame_done
   );

   modport slave (
      output data_in, valid_in, empty, out_ready,
      input  rd_en, out_data, out_valid, out_last, pixel_idx, frame_done
   );

endinterface

// File: rtl/fmap_stream_writer_pix_serializer.sv
// Loads one pixel vector and shifts it out LSB-first as OUT_W-bit words; owns the word counter.
import fmap_writer_pkg::*;

module pix_serializer #(
   parameter int unsigned VW    = 32,
   parameter int unsigned OUT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [VW-1:0]    data_i,
   input  logic             shift_i,
   output logic [OUT_W-1:0] word_o,
   output logic             last_word_o
);
   localparam int unsigned WPP = VW / OUT_W;
   localparam int unsigned CW  = cnt_w(WPP);

   logic [VW-1:0] shreg_q, shreg_d;
   logic [CW-1:0] word_cnt_q, word_cnt_d;

   assign word_o      = shreg_q[OUT_W-1:0];
   assign last_word_o = (word_cnt_q == CW'(WPP - 1));

   always_comb begin
      shreg_d    = shreg_q;
      word_cnt_d = word_cnt_q;
      if (load_i) begin
         shreg_d    = data_i;
         word_cnt_d = '0;
      end else if (shift_i) begin
         shreg_d = shreg_q >> OUT_W;
         // Saturate: the FSM leaves SEND on the last word, so no wrap is needed.
         if (!last_word_o) begin
            word_cnt_d = word_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shreg_q    <= '0;
         word_cnt_q <= '0;
      end else begin
         shreg_q    <= shreg_d;
         word_cnt_q <= word_cnt_d;
      end
   end

endmodule

// File: rtl/fmap_stream_writer.sv
// Feature-map output writer: pops pixels from the upstream FIFO and streams them as words.
// Define FMAP_WRITER_TAG_EN to prefix each pixel with a {first_pixel, pixel_idx} header word.
import fmap_writer_pkg::*;

module fmap_stream_writer #(
   parameter int unsigned CH           = DefCh,
   parameter int unsigned DW           = DefDw,
   parameter int unsigned OUT_W        = DefOutW,
   parameter int unsigned FRAME_PIXELS = DefFramePixels
) (
   input logic                  Clk,
   input logic                  RstN,
   fmap_stream_writer_if.master bus
);
   localparam int unsigned WPP = CH * DW / OUT_W;
   localparam int unsigned PW  = cnt_w(FRAME_PIXELS);

   if ((CH * DW) % OUT_W != 0) begin : g_bad_width
      $error("fmap_stream_writer: CH*DW must be a multiple of OUT_W");
   end

   state_e           state_q, state_d;
   logic [PW-1:0]    pix_q, pix_d;
   logic             accept;
   logic             shift;
   logic             last_word;
   logic [OUT_W-1:0] ser_word;
   logic [OUT_W-1:0] out_data;
   logic             out_valid;
   logic             out_last;
   logic             frame_done;
   logic             last_pix;

   assign last_pix = (pix_q == PW'(FRAME_PIXELS - 1));
   assign shift    = (state_q == StSend) && bus.out_ready;

   pix_serializer #(
      .VW    (CH * DW),
      .OUT_W (OUT_W)
   ) u_ser (
      .clk_i       (Clk),
      .rst_ni      (RstN),
      .load_i      (accept),
      .data_i      (bus.data_in),
      .shift_i     (shift),
      .word_o      (ser_word),
      .last_word_o (last_word)
   );

`ifdef FMAP_WRITER_TAG_EN
   logic [OUT_W-1:0] hdr_word;
   assign hdr_word = {(pix_q == '0), (OUT_W - 1)'(pix_q)};
`endif

   always_comb begin
      state_d    = state_q;
      pix_d      = pix_q;
      accept     = 1'b0;
      out_valid  = 1'b0;
      out_last   = 1'b0;
      frame_done = 1'b0;
      out_data   = ser_word;
      unique case (state_q)
         StIdle: begin
            accept = bus.valid_in && !bus.empty;
            if (accept) begin
`ifdef FMAP_WRITER_TAG_EN
               state_d = StTag;
`else
               state_d = StSend;
`endif
            end
         end
`ifdef FMAP_WRITER_TAG_EN
         StTag: begin
            out_valid = 1'b1;
            out_data  = hdr_word;
            if (bus.out_ready) begin
               state_d = StSend;
            end
         end
`endif
         StSend: begin
            out_valid = 1'b1;
            out_last  = last_word && last_pix;
            if (bus.out_ready && last_word) begin
               if (last_pix) begin
                  state_d = StDone;
                  pix_d   = '0;
               end else begin
                  state_d = StIdle;
                  pix_d   = pix_q + 1'b1;
               end
            end
         end
         StDone: begin
            frame_done = 1'b1;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         state_q <= StIdle;
         pix_q   <= '0;
      end else begin
         state_q <= state_d;
         pix_q   <= pix_d;
      end
   end

   assign bus.rd_en      = accept;
   assign bus.out_data   = out_data;
   assign bus.out_valid  = out_valid;
   assign bus.out_last   = out_last;
   assign bus.pixel_idx  = pix_q;
   assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_fmap_stream_writer.sv
// Directed bench for fmap_stream_writer with CH=4, DW=8, OUT_W=8, FRAME_PIXELS=3.
// Build with FMAP_WRITER_TAG_EN to exercise the per-pixel header words.
module tb_fmap_stream_writer;

   logic clk;
   logic rst_n;
   int   n_total;
   int   n_bad;

   fmap_stream_writer_if #(
      .CH           (4),
      .DW           (8),
      .OUT_W        (8),
      .FRAME_PIXELS (3)
   ) bus ();

   fmap_stream_writer #(
      .CH           (4),
      .DW           (8),
      .OUT_W        (8),
      .FRAME_PIXELS (3)
   ) dut (
      .Clk  (clk),
      .RstN (rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.valid_in  = 1'b0;
      bus.empty     = 1'b1;
      bus.out_ready = 1'b1;
      bus.data_in   = '0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   // Sends one pixel from IDLE with out_ready held high; words expected LSB byte first.
   task automatic send_pixel(input logic [31:0] px, input logic [31:0] pix, input logic [7:0] hdr,
                             input bit last_pix);
      bus.data_in   = px;
      bus.valid_in  = 1'b1;
      bus.empty     = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      check("rd_en_accept", bus.rd_en, 1);
      check("idle_no_valid", bus.out_valid, 0);
      step();
      bus.valid_in = 1'b0;
      bus.data_in  = 32'hDEADBEEF;
      #1;
      check("rd_en_one_cycle", bus.rd_en, 0);
`ifdef FMAP_WRITER_TAG_EN
      check("hdr_valid", bus.out_valid, 1);
      check("hdr_word", bus.out_data, {24'h0, hdr});
      check("hdr_last", bus.out_last, 0);
      step();
`else
      check("hdr_unused", {24'h0, hdr}, {24'h0, hdr} & 32'hff);
`endif
      for (int w = 0; w < 4; w++) begin
         check("word_valid", bus.out_valid, 1);
         check("word_data", bus.out_data, (px >> (8 * w)) & 32'hff);
         check("word_last", bus.out_last, (last_pix && w == 3) ? 1 : 0);
         check("word_pix", bus.pixel_idx, pix);
         check("word_no_done", bus.frame_done, 0);
         step();
      end
      check("end_valid_low", bus.out_valid, 0);
      if (last_pix) begin
         bus.valid_in = 1'b1;
         bus.empty    = 1'b0;
         #1;
         check("frame_done", bus.frame_done, 1);
         check("frame_pix_clear", bus.pixel_idx, 0);
         check("done_no_accept", bus.rd_en, 0);
         bus.valid_in = 1'b0;
         step();
         check("frame_done_pulse", bus.frame_done, 0);
      end else begin
         check("no_frame_done", bus.frame_done, 0);
         check("pix_advance", bus.pixel_idx, pix + 1);
      end
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      rst_n         = 1'b0;
      bus.valid_in  = 1'b0;
      bus.empty     = 1'b1;
      bus.out_ready = 1'b1;
      bus.data_in   = '0;
      #2;
      check("rst_valid", bus.out_valid, 0);
      check("rst_rd_en", bus.rd_en, 0);
      check("rst_data", bus.out_data, 0);
      check("rst_last", bus.out_last, 0);
      check("rst_pix", bus.pixel_idx, 0);
      check("rst_done", bus.frame_done, 0);
      do_reset();

      // Single pixel.
      send_pixel(32'h44332211, 0, 8'h80, 1'b0);

      // Reset after two words of pixel 1.
      bus.data_in  = 32'h88776655;
      bus.valid_in = 1'b1;
      bus.empty    = 1'b0;
      step();
      bus.valid_in = 1'b0;
`ifdef FMAP_WRITER_TAG_EN
      check("mid_hdr", bus.out_data, 32'h01);
      step();
`endif
      check("mid_w0", bus.out_data, 32'h55);
      step();
      check("mid_w1", bus.out_data, 32'h66);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check("async_valid", bus.out_valid, 0);
      check("async_data", bus.out_data, 0);
      check("async_pix", bus.pixel_idx, 0);
      check("async_last", bus.out_last, 0);
      check("async_done", bus.frame_done, 0);
      #3;
      rst_n = 1'b1;
      step();
      check("post_rst_done", bus.frame_done, 0);
      send_pixel(32'hA1B2C3D4, 0, 8'h80, 1'b0);

      // valid_in with empty FIFO is ignored.
      do_reset();
      bus.valid_in = 1'b1;
      bus.empty    = 1'b1;
      bus.data_in  = 32'h12345678;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("empty_rd_en", bus.rd_en, 0);
         check("empty_valid", bus.out_valid, 0);
         step();
      end
      bus.valid_in = 1'b0;

      // Stall with out_ready 1,0,0,1 while word 0x22 is presented.
      bus.data_in  = 32'h44332211;
      bus.valid_in = 1'b1;
      bus.empty    = 1'b0;
      step();
      bus.valid_in = 1'b0;
`ifdef FMAP_WRITER_TAG_EN
      step();
`endif
      check("stall_w0", bus.out_data, 32'h11);
      step();
      bus.out_ready = 1'b0;
      #1;
      check("stall_w1_a", bus.out_data, 32'h22);
      step();
      check("stall_w1_b", bus.out_data, 32'h22);
      check("stall_valid", bus.out_valid, 1);
      step();
      bus.out_ready = 1'b1;
      #1;
      check("stall_w1_c", bus.out_data, 32'h22);
      step();
      check("stall_w2", bus.out_data, 32'h33);
      step();
      check("stall_w3", bus.out_data, 32'h44);
      step();
      check("stall_end", bus.out_valid, 0);
      check("stall_pix", bus.pixel_idx, 1);

      // Full frame of three pixels, then a fourth restarting at index 0.
      do_reset();
      send_pixel(32'h04030201, 0, 8'h80, 1'b0);
      send_pixel(32'h14131211, 1, 8'h01, 1'b0);
      send_pixel(32'h24232221, 2, 8'h02, 1'b1);
      send_pixel(32'h34333231, 0, 8'h80, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
